// File: rtl/uart_transceiver_if.sv
// Host-side bundle for the UART core: TX valid/ready stream in, RX valid/ready stream out.
// Ports: tx_data/tx_valid/tx_ready (host -> core), rx_data/rx_valid/rx_ready plus
//   rx_parity_err/rx_frame_err/rx_overrun (core -> host).
// master = host / consumer side, slave = UART core side.
interface uart_transceiver_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 rx_parity_err;
  logic                 rx_frame_err;
  logic                 rx_overrun;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun
  );
endinterface

// File: rtl/uart_transceiver.sv
// Full-duplex UART core: valid/ready TX framer and majority-voted RX deframer with error flags.
// Latency: tx_serial starts the cycle after accept; rx_valid rises the cycle after the stop-bit vote.
// Backpressure: tx_ready low for the whole frame; RX frames arriving while rx_valid is unread are dropped (rx_overrun).
// Ports: clk, rst (async, active-low), parity_type (0/3 none, 1 odd, 2 even), two_stop,
//   tx_serial (line out, idle high), rx_serial (async line in), bus (uart_transceiver_if.slave).
module uart_transceiver #(
  parameter int DATA_BITS       = 8,
  parameter int CLOCKS_PER_BIT  = 434,
  parameter int CLOCK_CTR_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        parity_type,
  input  logic              two_stop,
  output logic              tx_serial,
  input  logic              rx_serial,
  uart_transceiver_if.slave bus
);

  localparam int BIT_CTR_WIDTH = $clog2(DATA_BITS + 1);
  localparam logic [CLOCK_CTR_WIDTH-1:0] LAST_CNT  = CLOCK_CTR_WIDTH'(CLOCKS_PER_BIT - 1);
  localparam logic [CLOCK_CTR_WIDTH-1:0] READY_CNT = CLOCK_CTR_WIDTH'(CLOCKS_PER_BIT - 2);
  localparam logic [CLOCK_CTR_WIDTH-1:0] SMP0      = CLOCK_CTR_WIDTH'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CLOCK_CTR_WIDTH-1:0] SMP1      = CLOCK_CTR_WIDTH'(CLOCKS_PER_BIT / 2);
  localparam logic [CLOCK_CTR_WIDTH-1:0] SMP2      = CLOCK_CTR_WIDTH'(CLOCKS_PER_BIT / 2 + 1);
  localparam logic [BIT_CTR_WIDTH-1:0]   LAST_BIT  = BIT_CTR_WIDTH'(DATA_BITS - 1);

  // ---------------------------------------------------------------- TX
  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2
  } tx_state_t;

  tx_state_t                  tx_state;
  logic [CLOCK_CTR_WIDTH-1:0] tx_cnt;
  logic [BIT_CTR_WIDTH-1:0]   tx_bit;
  logic [DATA_BITS-1:0]       tx_shift;
  logic                       tx_par_en;
  logic                       tx_par_bit;
  logic                       tx_two;
  logic                       tx_serial_q;
  logic                       tx_ready_q;

  logic tx_accept;
  logic tx_bit_end;
  logic tx_last_stop;

  assign tx_accept    = bus.tx_valid && tx_ready_q;
  assign tx_bit_end   = (tx_cnt == LAST_CNT);
  assign tx_last_stop = (tx_state == TX_STOP2) || ((tx_state == TX_STOP1) && !tx_two);

  assign tx_serial    = tx_serial_q;
  assign bus.tx_ready = tx_ready_q;

  // tx_ready_q is only high in IDLE and on the last cycle of the final stop bit,
  // so an accept here either starts from idle or chains a frame with no gap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state    <= TX_IDLE;
      tx_cnt      <= '0;
      tx_bit      <= '0;
      tx_shift    <= '0;
      tx_par_en   <= 1'b0;
      tx_par_bit  <= 1'b0;
      tx_two      <= 1'b0;
      tx_serial_q <= 1'b1;
      tx_ready_q  <= 1'b1;
    end else if (tx_accept) begin
      tx_state    <= TX_START;
      tx_cnt      <= '0;
      tx_bit      <= '0;
      tx_shift    <= bus.tx_data;
      tx_par_en   <= (parity_type == 2'd1) || (parity_type == 2'd2);
      tx_par_bit  <= (parity_type == 2'd1) ? ~^bus.tx_data : ^bus.tx_data;
      tx_two      <= two_stop;
      tx_serial_q <= 1'b0;
      tx_ready_q  <= 1'b0;
    end else if (tx_state != TX_IDLE) begin
      tx_cnt <= tx_bit_end ? '0 : tx_cnt + 1'b1;
      // Registered ready: raise one cycle early so it is high on the last stop cycle.
      if (tx_last_stop && (tx_cnt == READY_CNT)) begin
        tx_ready_q <= 1'b1;
      end
      if (tx_bit_end) begin
        case (tx_state)
          TX_START: begin
            tx_state    <= TX_DATA;
            tx_serial_q <= tx_shift[0];
            tx_shift    <= {1'b0, tx_shift[DATA_BITS-1:1]};
            tx_bit      <= '0;
          end
          TX_DATA: begin
            if (tx_bit == LAST_BIT) begin
              if (tx_par_en) begin
                tx_state    <= TX_PARITY;
                tx_serial_q <= tx_par_bit;
              end else begin
                tx_state    <= TX_STOP1;
                tx_serial_q <= 1'b1;
              end
            end else begin
              tx_serial_q <= tx_shift[0];
              tx_shift    <= {1'b0, tx_shift[DATA_BITS-1:1]};
              tx_bit      <= tx_bit + 1'b1;
            end
          end
          TX_PARITY: begin
            tx_state    <= TX_STOP1;
            tx_serial_q <= 1'b1;
          end
          TX_STOP1: begin
            tx_state <= tx_two ? TX_STOP2 : TX_IDLE;
          end
          default: begin
            tx_state <= TX_IDLE;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------- RX
  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_t;

  rx_state_t                  rx_state;
  logic                       rx_s1;
  logic                       rx_s2;
  logic                       rx_prev;
  logic [CLOCK_CTR_WIDTH-1:0] rx_cnt;
  logic [BIT_CTR_WIDTH-1:0]   rx_bit;
  logic [DATA_BITS-1:0]       rx_shift;
  logic [1:0]                 rx_ptype;
  logic                       rx_par_bit;
  logic                       rx_smp0;
  logic                       rx_smp1;
  logic [DATA_BITS-1:0]       rx_data_q;
  logic                       rx_valid_q;
  logic                       rx_perr_q;
  logic                       rx_ferr_q;
  logic                       rx_ovr_q;

  logic rx_vote;
  logic rx_bit_end;
  logic rx_par_en;
  logic rx_ones_odd;
  logic rx_perr_calc;
  logic rx_stop_vote;
  logic rx_read;

  // Third sample is the live synchronised bit; the first two were captured earlier.
  assign rx_vote      = (rx_smp0 & rx_smp1) | (rx_smp0 & rx_s2) | (rx_smp1 & rx_s2);
  assign rx_bit_end   = (rx_cnt == LAST_CNT);
  assign rx_par_en    = (rx_ptype == 2'd1) || (rx_ptype == 2'd2);
  assign rx_ones_odd  = ^{rx_shift, rx_par_bit};
  assign rx_perr_calc = ((rx_ptype == 2'd1) && !rx_ones_odd) ||
                        ((rx_ptype == 2'd2) &&  rx_ones_odd);
  assign rx_stop_vote = (rx_state == RX_STOP) && (rx_cnt == SMP2);
  assign rx_read      = rx_valid_q && bus.rx_ready;

  assign bus.rx_data       = rx_data_q;
  assign bus.rx_valid      = rx_valid_q;
  assign bus.rx_parity_err = rx_perr_q;
  assign bus.rx_frame_err  = rx_ferr_q;
  assign bus.rx_overrun    = rx_ovr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state   <= RX_IDLE;
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_prev    <= 1'b1;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      rx_ptype   <= 2'd0;
      rx_par_bit <= 1'b0;
      rx_smp0    <= 1'b0;
      rx_smp1    <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      rx_s1   <= rx_serial;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;

      case (rx_state)
        RX_IDLE: begin
          // The first synchronised low cycle counts as count 0 of the start bit.
          if (rx_prev && !rx_s2) begin
            rx_state <= RX_START;
            rx_cnt   <= CLOCK_CTR_WIDTH'(1);
            rx_ptype <= parity_type;
          end
        end
        default: begin
          rx_cnt <= rx_bit_end ? '0 : rx_cnt + 1'b1;
          if (rx_cnt == SMP0) rx_smp0 <= rx_s2;
          if (rx_cnt == SMP1) rx_smp1 <= rx_s2;
          if (rx_bit_end) begin
            case (rx_state)
              RX_START: begin
                rx_state <= RX_DATA;
                rx_bit   <= '0;
              end
              RX_DATA: begin
                if (rx_bit == LAST_BIT) begin
                  rx_state <= rx_par_en ? RX_PARITY : RX_STOP;
                end else begin
                  rx_bit <= rx_bit + 1'b1;
                end
              end
              RX_PARITY: rx_state <= RX_STOP;
              default: ;
            endcase
          end
          // Placed after the bit-end transitions: with the shortest bit period the
          // vote lands on the last count, and returning to IDLE must win.
          if (rx_cnt == SMP2) begin
            case (rx_state)
              RX_START: begin
                if (rx_vote) begin
                  rx_state <= RX_IDLE;
                  rx_cnt   <= '0;
                end
              end
              RX_DATA:   rx_shift   <= {rx_vote, rx_shift[DATA_BITS-1:1]};
              RX_PARITY: rx_par_bit <= rx_vote;
              RX_STOP: begin
                rx_state <= RX_IDLE;
                rx_cnt   <= '0;
              end
              default: ;
            endcase
          end
        end
      endcase

      // A frame completing during a read replaces the data and keeps rx_valid high.
      if (rx_stop_vote) begin
        if (!rx_valid_q || bus.rx_ready) begin
          rx_data_q  <= rx_shift;
          rx_perr_q  <= rx_perr_calc;
          rx_ferr_q  <= ~rx_vote;
          rx_valid_q <= 1'b1;
        end else begin
          rx_ovr_q <= 1'b1;
        end
      end else if (rx_read) begin
        rx_valid_q <= 1'b0;
      end
      if (rx_read) begin
        rx_ovr_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_transceiver.sv
// Bench for uart_transceiver: loopback and directly driven RX frames, randomized data and
// framing options, compared against a frame-level reference model.
module tb_uart_transceiver;
  localparam int DB  = 8;
  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] parity_type;
  logic       two_stop;
  logic       tx_serial;
  logic       rx_serial;
  logic       drv_rx;
  logic       loop;

  uart_transceiver_if #(.DATA_BITS(DB)) bus();

  assign rx_serial = loop ? tx_serial : drv_rx;

  uart_transceiver #(
    .DATA_BITS(DB),
    .CLOCKS_PER_BIT(CPB),
    .CLOCK_CTR_WIDTH(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .parity_type(parity_type),
    .two_stop(two_stop),
    .tx_serial(tx_serial),
    .rx_serial(rx_serial),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } rx_exp_t;

  rx_exp_t exp_q[$];
  logic    m_overrun;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic par_bit(input logic [7:0] d, input logic [1:0] pt);
    int ones;
    ones = $countones(d);
    if (pt == 2'd1) return (ones % 2) == 0;
    return (ones % 2) == 1;
  endfunction

  // Single-entry receive buffer: a completed frame lands only if the buffer is empty
  // (rx_ready is held low by this bench outside of reads), otherwise it is lost.
  task automatic model_frame(input logic [7:0] d, input logic perr, input logic ferr);
    rx_exp_t e;
    e.data = d;
    e.perr = perr;
    e.ferr = ferr;
    if (exp_q.size() == 0) exp_q.push_back(e);
    else m_overrun = 1'b1;
  endtask

  task automatic tx_frame(input logic [7:0] d, input logic [1:0] pt, input logic ts);
    logic bits[$];
    int   n;
    bits = {};
    bits.push_back(1'b0);
    for (int i = 0; i < DB; i++) bits.push_back(d[i]);
    if (pt == 2'd1 || pt == 2'd2) bits.push_back(par_bit(d, pt));
    bits.push_back(1'b1);
    if (ts) bits.push_back(1'b1);

    n = 0;
    @(negedge clk);
    while (!bus.tx_ready && n < 20 * CPB) begin
      @(negedge clk);
      n++;
    end
    check("tx_ready_wait", bus.tx_ready, 1);
    @(posedge clk); #1;
    bus.tx_data  = d;
    parity_type  = pt;
    two_stop     = ts;
    bus.tx_valid = 1'b1;
    @(posedge clk); #1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'($urandom);
    for (int b = 0; b < bits.size(); b++) begin
      for (int j = 1; j <= CPB; j++) begin
        @(negedge clk);
        if (b == 0 && j == 1) check("tx_ready_drop", bus.tx_ready, 0);
        if (b == 2 && j == 1) begin
          parity_type = 2'($urandom_range(3));
          two_stop    = 1'($urandom_range(1));
        end
        if (j == CPB / 2) check($sformatf("tx_bit%0d_d%02h", b, d), tx_serial, bits[b]);
        if (b == bits.size() - 1 && j == CPB - 1) check("tx_ready_early", bus.tx_ready, 0);
        if (b == bits.size() - 1 && j == CPB) check("tx_ready_rise", bus.tx_ready, 1);
      end
    end
    model_frame(d, 1'b0, 1'b0);
  endtask

  task automatic rx_drive(input logic [7:0] d, input logic [1:0] pt, input logic pbit,
                          input logic stop);
    logic bits[$];
    logic perr;
    bits = {};
    bits.push_back(1'b0);
    for (int i = 0; i < DB; i++) bits.push_back(d[i]);
    if (pt == 2'd1 || pt == 2'd2) bits.push_back(pbit);
    bits.push_back(stop);
    parity_type = pt;
    @(posedge clk); #1;
    for (int b = 0; b < bits.size(); b++) begin
      drv_rx = bits[b];
      repeat (CPB) @(posedge clk);
      #1;
    end
    drv_rx = 1'b1;
    perr = (pt == 2'd1 || pt == 2'd2) ? (pbit != par_bit(d, pt)) : 1'b0;
    model_frame(d, perr, ~stop);
  endtask

  task automatic rx_read();
    rx_exp_t e;
    int      n;
    n = 0;
    @(negedge clk);
    while (!bus.rx_valid && n < 4 * CPB) begin
      @(negedge clk);
      n++;
    end
    check("rx_valid", bus.rx_valid, 1);
    e.data = 8'h00;
    e.perr = 1'b0;
    e.ferr = 1'b0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    check("rx_data", bus.rx_data, e.data);
    check("rx_parity_err", bus.rx_parity_err, e.perr);
    check("rx_frame_err", bus.rx_frame_err, e.ferr);
    check("rx_overrun", bus.rx_overrun, m_overrun);
    @(posedge clk); #1;
    bus.rx_ready = 1'b1;
    @(posedge clk); #1;
    bus.rx_ready = 1'b0;
    m_overrun    = 1'b0;
    @(negedge clk);
    check("rx_valid_clr", bus.rx_valid, 0);
    check("rx_overrun_clr", bus.rx_overrun, m_overrun);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b0;
    loop         = 1'b1;
    drv_rx       = 1'b1;
    parity_type  = 2'd0;
    two_stop     = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    bus.rx_ready = 1'b0;
    m_overrun    = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_serial", tx_serial, 1);
    check("rst_tx_ready", bus.tx_ready, 1);
    check("rst_rx_valid", bus.rx_valid, 0);
    check("rst_rx_data", bus.rx_data, 0);
    check("rst_perr", bus.rx_parity_err, 0);
    check("rst_ferr", bus.rx_frame_err, 0);
    check("rst_overrun", bus.rx_overrun, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Loopback, fixed frames.
    tx_frame(8'hA5, 2'd0, 1'b0); rx_read();
    tx_frame(8'h03, 2'd1, 1'b0); rx_read();
    tx_frame(8'h03, 2'd2, 1'b0); rx_read();
    tx_frame(8'h3C, 2'd3, 1'b1); rx_read();

    // Loopback, randomized data / parity / stop bits.
    for (int i = 0; i < 10; i++) begin
      tx_frame(8'($urandom), 2'($urandom_range(3)), 1'($urandom_range(1)));
      rx_read();
    end

    // Directly driven RX frames.
    loop = 1'b0;
    rx_drive(8'h07, 2'd2, 1'b0, 1'b1); rx_read();
    rx_drive(8'h07, 2'd2, 1'b1, 1'b1); rx_read();
    rx_drive(8'h07, 2'd1, 1'b1, 1'b1); rx_read();
    rx_drive(8'hC3, 2'd0, 1'b0, 1'b0); rx_read();
    for (int i = 0; i < 6; i++) begin
      rx_drive(8'($urandom), 2'($urandom_range(3)), 1'($urandom_range(1)),
               1'($urandom_range(3) != 0));
      rx_read();
    end

    // Short low glitch on an idle line must not produce a frame.
    @(posedge clk); #1;
    drv_rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    drv_rx = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    check("glitch_no_valid", bus.rx_valid, 0);

    // Overrun: second frame arrives while the first is unread.
    loop = 1'b1;
    tx_frame(8'h11, 2'd0, 1'b0);
    tx_frame(8'h22, 2'd0, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    check("ovr_set", bus.rx_overrun, 1);
    rx_read();

    // Reset in the middle of a data bit.
    parity_type = 2'd0;
    two_stop    = 1'b0;
    @(posedge clk); #1;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b1;
    @(posedge clk); #1;
    bus.tx_valid = 1'b0;
    repeat (2 * CPB + CPB / 2) @(posedge clk);
    #1;
    check("mid_data_low", tx_serial, 0);
    rst = 1'b0;
    #1;
    check("arst_tx_serial", tx_serial, 1);
    check("arst_tx_ready", bus.tx_ready, 1);
    check("arst_rx_valid", bus.rx_valid, 0);
    exp_q.delete();
    m_overrun = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("post_rst_no_valid", bus.rx_valid, 0);
    check("post_rst_tx_serial", tx_serial, 1);
    tx_frame(8'h5A, 2'd1, 1'b1); rx_read();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
